// File: rtl/prog_loader.sv
// Host byte-stream loader for the 9-bit-instruction core.
// Fills instruction memory, runs the core, and times the run.
module prog_loader #(
  parameter int IW    = 9,
  parameter int AW    = 6,
  parameter int DEPTH = 64,
  parameter int CW    = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [IW-1:0] wr_data,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          run_done,
  output logic          err,
  output logic [CW-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LO, S_HI,
    S_WR, S_RUN, S_DONE, S_ERR
  } state_t;

  localparam logic [AW:0]   PONE  = 1;
  localparam logic [CW-1:0] CONE  = 1;
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] CLAST = CMAX - CONE;

  state_t state, state_nx;

  // ptr/count carry one extra bit so a full 64-word load compares cleanly
  logic [AW:0] ptr;
  logic [AW:0] count;
  logic [7:0]  lo;

  logic xfer;
  logic hdr_bad;
  logic hi_bad;
  logic last;
  logic wd_hit;

  assign in_ready = (state == S_HDR) ||
                    (state == S_LO)  ||
                    (state == S_HI);
  assign xfer    = in_valid & in_ready;
  assign hdr_bad = (in_data == 8'd0) ||
                   (int'(in_data) > DEPTH);
  assign hi_bad  = (in_data[7:1] != 7'd0);
  assign last    = (ptr == count - PONE);
  assign wd_hit  = (cycles == CLAST);

  always_comb begin
    state_nx   = state;
    wr_en      = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;
    run_done   = 1'b0;
    err        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_HDR;
      end
      S_HDR: begin
        busy = 1'b1;
        if (xfer) state_nx = hdr_bad ? S_ERR : S_LO;
      end
      S_LO: begin
        busy = 1'b1;
        if (xfer) state_nx = S_HI;
      end
      S_HI: begin
        busy = 1'b1;
        if (xfer) state_nx = hi_bad ? S_ERR : S_WR;
      end
      S_WR: begin
        busy     = 1'b1;
        wr_en    = 1'b1;
        state_nx = last ? S_RUN : S_LO;
      end
      S_RUN: begin
        busy       = 1'b1;
        core_reset = 1'b0;
        if (core_done)   state_nx = S_DONE;
        else if (wd_hit) state_nx = S_ERR;
      end
      S_DONE: begin
        run_done = 1'b1;
        if (start) state_nx = S_HDR;
      end
      S_ERR: begin
        err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      count   <= '0;
      lo      <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      cycles  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_HDR: begin
          if (xfer && !hdr_bad) begin
            count <= in_data[AW:0];
            ptr   <= '0;
          end
        end
        S_LO: begin
          if (xfer) lo <= in_data;
        end
        S_HI: begin
          if (xfer) begin
            wr_data <= IW'({in_data[0], lo});
            wr_addr <= ptr[AW-1:0];
          end
        end
        S_WR: begin
          ptr <= ptr + PONE;
          if (last) cycles <= '0;
        end
        S_RUN: begin
          if (!core_done && cycles != CMAX)
            cycles <= cycles + CONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard.
// A CW=4 instance shares the stimulus to reach the watchdog.
module tb_prog_loader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        core_done;

  logic        in_ready, wr_en, core_reset;
  logic        busy, run_done, err;
  logic [5:0]  wr_addr;
  logic [8:0]  wr_data;
  logic [15:0] cycles;

  logic        w_in_ready, w_wr_en, w_core_reset;
  logic        w_busy, w_run_done, w_err;
  logic [5:0]  w_wr_addr;
  logic [8:0]  w_wr_data;
  logic [3:0]  w_cycles;

  int checks = 0;
  int errors = 0;

  logic [14:0] exp_q[$];
  logic [8:0]  prog[64];

  always #5 Clk = ~Clk;

  prog_loader u_dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .core_reset(core_reset), .core_done(core_done),
    .busy(busy), .run_done(run_done),
    .err(err), .cycles(cycles)
  );

  prog_loader #(.CW(4)) u_wd (
    .Clk(Clk), .Reset(Reset), .start(start),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(w_in_ready), .wr_en(w_wr_en),
    .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .core_reset(w_core_reset), .core_done(core_done),
    .busy(w_busy), .run_done(w_run_done),
    .err(w_err), .cycles(w_cycles)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", {17'd0, wr_addr, wr_data}, 32'hFFFF);
      end else begin
        chk("wr_addr_data", {17'd0, wr_addr, wr_data},
            {17'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    Reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    core_done = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit tog);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 64) begin
      @(negedge Clk);
      n++;
    end
    chk("ready_wait", n < 64, 1);
    @(negedge Clk);
    if (tog) begin
      in_valid = 1'b0;
      in_data  = 8'hEE;
      @(negedge Clk);
    end
  endtask

  task automatic load(input int n, input logic [7:0] hdr,
                      input bit tog);
    logic [5:0] a;
    logic [8:0] w;
    send(hdr, tog);
    for (int i = 0; i < n; i++) begin
      a = i[5:0];
      w = prog[i];
      exp_q.push_back({a, w});
      send(w[7:0], tog);
      send({7'd0, w[8]}, tog);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (core_reset && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("run_entry_wait", n < 100, 1);
  endtask

  task automatic run_core(input int n);
    repeat (n) @(negedge Clk);
    core_done = 1'b1;
    @(negedge Clk);
    core_done = 1'b0;
  endtask

  initial begin
    int n;
    do_reset();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_run_done", run_done, 0);
    chk("rst_err", err, 0);
    chk("rst_cycles", cycles, 0);

    core_done = 1'b1;
    @(negedge Clk);
    core_done = 1'b0;
    chk("idle_done_ignored", run_done, 0);

    // streamed three-word program
    prog[0] = 9'h1A5;
    prog[1] = 9'h03C;
    prog[2] = 9'h1FF;
    pulse_start();
    chk("hdr_busy", busy, 1);
    chk("hdr_ready", in_ready, 1);
    load(3, 8'h03, 1'b0);
    chk("t1_wr_last", wr_en, 1);
    chk("t1_creset_in_wr", core_reset, 1);
    @(negedge Clk);
    chk("t1_creset_fall", core_reset, 0);
    chk("t1_cycles_zero", cycles, 0);
    run_core(10);
    chk("t1_run_done", run_done, 1);
    chk("t1_cycles", cycles, 10);
    chk("t1_core_reset", core_reset, 1);
    chk("t1_busy", busy, 0);
    chk("t1_q_empty", exp_q.size(), 0);

    // restart from DONE with a stalling host
    pulse_start();
    chk("t2_busy", busy, 1);
    chk("t2_cycles_hold", cycles, 10);
    load(3, 8'h03, 1'b1);
    wait_run();
    chk("t2_cycles_zero", cycles, 0);
    run_core(7);
    chk("t2_run_done", run_done, 1);
    chk("t2_cycles", cycles, 7);
    chk("t2_q_empty", exp_q.size(), 0);

    // header 00
    do_reset();
    pulse_start();
    send(8'h00, 1'b0);
    in_valid = 1'b0;
    chk("h00_err", err, 1);
    chk("h00_ready", in_ready, 0);
    pulse_start();
    @(negedge Clk);
    chk("h00_start_ign", err, 1);
    chk("h00_busy", busy, 0);
    do_reset();
    chk("h00_err_clr", err, 0);

    // header 65
    pulse_start();
    send(8'h41, 1'b0);
    in_valid = 1'b0;
    chk("h41_err", err, 1);
    chk("h41_ready", in_ready, 0);
    do_reset();
    chk("h41_err_clr", err, 0);

    // full 64-word program
    for (int i = 0; i < 64; i++)
      prog[i] = 9'((i * 37 + 5) & 9'h1FF);
    pulse_start();
    load(64, 8'h40, 1'b0);
    chk("f_wr_en", wr_en, 1);
    chk("f_wr_addr", wr_addr, 6'h3F);
    chk("f_wr_data", wr_data, prog[63]);
    @(negedge Clk);
    chk("f_run", core_reset, 0);
    chk("f_no_65th", wr_en, 0);
    chk("f_q_empty", exp_q.size(), 0);
    repeat (3) @(negedge Clk);
    pulse_start();
    chk("run_start_ign", core_reset, 0);
    chk("run_busy", busy, 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("mid_rst_creset", core_reset, 1);
    chk("mid_rst_cycles", cycles, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);

    // bad high byte on word 0
    pulse_start();
    send(8'h01, 1'b0);
    send(8'h55, 1'b0);
    send(8'h02, 1'b0);
    in_valid = 1'b0;
    chk("hi_err", err, 1);
    chk("hi_ready", in_ready, 0);
    do_reset();

    // watchdog on the CW=4 instance
    prog[0] = 9'h123;
    pulse_start();
    load(1, 8'h01, 1'b0);
    wait_run();
    n = 0;
    while (!w_err && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("wd_run_len", n, 15);
    chk("wd_cycles", w_cycles, 4'hF);
    chk("wd_core_reset", w_core_reset, 1);
    chk("wd_run_done", w_run_done, 0);
    chk("wd_main_busy", busy, 1);
    chk("wd_main_cycles", cycles, 15);
    do_reset();
    chk("wd_err_clr", w_err, 0);
    chk("end_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side program loader for the 9-bit-instruction core.
- Accepts a byte-serial stream from the bench/host over a valid/ready handshake and writes 9-bit machine-code words into instruction memory at ascending addresses.
- Holds the core in reset during loading, releases it to run, then waits for the core's Done.
- Reports the run length in cycles and flags any error.

Parameters:
- IW, 9: instruction word width.
- AW, 6: instruction address width; matches the 6-bit PC.
- DEPTH, 64: instruction memory depth; the maximum word count.
- CW, 16: width of the run-cycle counter.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE and DONE.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader accepts the byte this cycle.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  AW  instruction memory write address.
- wr_data  out  IW  instruction memory write data.
- core_reset  out  1  reset to the core; high = held in reset.
- core_done  in  1  Done from the core.
- busy  out  1  high in HDR, LO, HI, WR, RUN.
- run_done  out  1  high in DONE.
- err  out  1  sticky error; high in ERR.
- cycles  out  CW  core run cycles, saturating at all-ones.

Behaviour:
- Reset values:
  - State = IDLE.
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - core_reset=1, busy=0, run_done=0, err=0, cycles=0.
- Handshake: a byte transfers on a cycle where in_valid and in_ready are both high. in_ready is a function of state only, never of in_valid. in_data is ignored when no transfer occurs.
- States:
  - IDLE: core_reset=1, in_ready=0. On start → HDR.
  - HDR: in_ready=1. On transfer:
    - in_data==0 or in_data>DEPTH → ERR.
    - Otherwise count<=in_data, ptr<=0 → LO.
  - LO: in_ready=1. On transfer, lo<=in_data → HI.
  - HI: in_ready=1. On transfer:
    - wr_data<={in_data[0],lo}; wr_addr<=ptr.
    - If in_data[7:1]!=0 → ERR. No write occurs for that word.
    - Otherwise → WR.
  - WR: one cycle, wr_en=1, in_ready=0. ptr<=ptr+1.
    - If ptr==count-1 → RUN, with cycles<=0.
    - Otherwise → LO.
    - wr_en is high only in WR: exactly one write per word, with addresses 0..count-1 in order.
  - RUN: core_reset=0, in_ready=0. cycles increments each cycle and saturates at 2^CW-1.
    - core_done sampled high → DONE. cycles is not incremented on that cycle.
    - cycles reaches 2^CW-1 without core_done → ERR (watchdog).
  - DONE: core_reset=1, run_done=1, cycles frozen. On start → HDR; cycles keeps its value until RUN is re-entered.
  - ERR: core_reset=1, err=1, in_ready=0. Only Reset exits; start is ignored.
- Boundary conditions:
  - start outside IDLE/DONE is ignored.
  - count=64 is legal: the final write is at address 63, and ptr must not wrap before the compare. ptr is AW+1 bits wide or compared against count-1.
  - core_done high in any state other than RUN is ignored.
  - Host stalls (in_valid low) in HDR/LO/HI hold state indefinitely; there is no timeout during load.
  - Reset mid-load or mid-run returns to IDLE the next edge, with all outputs at reset values. Partial memory contents are not cleared.
  - wr_addr/wr_data hold their last values outside WR.

Test Plan:
- Reset, start, stream 03, then pairs (A5,01), (3C,00), (FF,01) with in_valid held high:
  - Three wr_en pulses with addr/data 0/1A5, 1/03C, 2/1FF.
  - core_reset falls the cycle after the third write.
  - Assert core_done 10 cycles later → run_done=1, cycles=10, core_reset=1.
- Same stream with in_valid toggling every other cycle → identical writes and order. No byte is accepted while in_valid is low.
- Header 00, and separately header 41 (65) → ERR: err=1, no wr_en pulse, in_ready=0. start is ignored until Reset, which clears err.
- Header 40 with 64 words → last write at addr 3F (data equal to the final pair), then RUN. No 65th write.
- High byte 02 on word 0 → ERR, no write. Assert Reset mid-RUN on a separate run → IDLE next cycle, core_reset=1, cycles=0.
- CW overridden to 4, core_done never asserted → ERR after 15 RUN cycles, cycles=F. A second start from DONE after a normal run reloads and restarts cycles from 0.
